// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: FSM state encoding, byte-enable constants, default sizing and the alignment rule.
package dmem_responder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam int DEF_LATENCY     = 2;
  localparam int DEF_DEPTH_WORDS = 1024;
  function automatic logic misaligned(input logic [3:0] be, input logic [1:0] a);
    return (be == BE_WORD || be == BE_HALF_LO) ? a != 2'd0 :
           (be == BE_HALF_HI) ? a != 2'd2 :
           $onehot(be) ? be != (4'b0001 << a) : 1'b1;
  endfunction
endpackage

// File: rtl/be_ram.sv
// be_ram: single-port word RAM with per-byte write enables and a registered read port.
module be_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          re,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q, rdata_d;
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  end
  // read data only moves on an issued read, so it holds between responses
  always_comb rdata_d = re ? mem[addr] : rdata_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata_q <= '0;
    else      rdata_q <= rdata_d;
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: M-stage data memory responder; stalls the pipeline for a fixed latency per access.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int LATENCY     = DEF_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        stallM,
  output logic        rdata_valid,
  output logic [31:0] rdataM,
  output logic        err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          write_q, write_d, mis_q, mis_d;
  logic [AW-1:0] idx_q, idx_d, req_idx, ram_idx;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic          rdata_valid_q, rdata_valid_d, err_q, err_d;
  logic          rd_en, wr_en;
  logic          unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW+2];
  assign req_idx = req_addr[AW+1:2];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    mis_d   = mis_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        write_d = req_write;
        idx_d   = req_idx;
        wdata_d = req_wdata;
        be_d    = req_be;
        mis_d   = misaligned(req_be, req_addr[1:0]);
        cnt_d   = 4'(LATENCY - 1);
        state_d = (LATENCY == 1) ? RESP : WAIT;
        rd_en   = (LATENCY == 1);
      end
      // a dropped req_valid is a flush: abandon the access before any read or write
      WAIT: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = !req_valid ? IDLE : (cnt_q == 4'd1) ? RESP : WAIT;
        rd_en   = req_valid && cnt_q == 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  assign rdata_valid_d = state_d == RESP;
  assign err_d         = state_d == RESP && mis_d;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      write_q       <= 1'b0;
      idx_q         <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      mis_q         <= 1'b0;
      rdata_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      write_q       <= write_d;
      idx_q         <= idx_d;
      wdata_q       <= wdata_d;
      be_q          <= be_d;
      mis_q         <= mis_d;
      rdata_valid_q <= rdata_valid_d;
      err_q         <= err_d;
    end
  end
  assign ram_idx     = (state_q == IDLE) ? req_idx : idx_q;
  assign wr_en       = state_q == RESP && write_q && !err_q;
  assign stallM      = rst && req_valid && state_q != RESP;
  assign rdata_valid = rdata_valid_q;
  assign err         = err_q;
  be_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .re    (rd_en),
    .we    (wr_en),
    .be    (be_q),
    .addr  (ram_idx),
    .wdata (wdata_q),
    .rdata (rdataM)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: three responders (latency 1, 2, 4) checked against a word-array memory model.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rv [3];
  logic        rw [3];
  logic [31:0] ra [3];
  logic [31:0] rwd [3];
  logic [3:0]  rbe [3];
  logic        st [3];
  logic        dv [3];
  logic        er [3];
  logic [31:0] rd [3];
  logic [31:0] mem [3][1024];
  bit          known [3][1024];
  logic [31:0] hold [3];
  bit          hold_ok [3];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] got;
  logic [3:0]  bes [7] = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_write(rw[0]), .req_addr(ra[0]),
    .req_wdata(rwd[0]), .req_be(rbe[0]), .stallM(st[0]), .rdata_valid(dv[0]), .rdataM(rd[0]), .err(er[0]));
  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_write(rw[1]), .req_addr(ra[1]),
    .req_wdata(rwd[1]), .req_be(rbe[1]), .stallM(st[1]), .rdata_valid(dv[1]), .rdataM(rd[1]), .err(er[1]));
  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .req_valid(rv[2]), .req_write(rw[2]), .req_addr(ra[2]),
    .req_wdata(rwd[2]), .req_be(rbe[2]), .stallM(st[2]), .rdata_valid(dv[2]), .rdataM(rd[2]), .err(er[2]));

  always #5 clk = ~clk;

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'((a >> 2) % 32'd1024);
  endfunction

  // legal: full word at lane 0, halves at lanes 0/2, single byte at its own lane
  function automatic bit mis(logic [3:0] be, logic [1:0] a);
    bit ok;
    ok = (be == 4'hF && a == 0) || (be == 4'h3 && a == 0) || (be == 4'hC && a == 2) ||
         (be == (4'b0001 << a));
    return !ok;
  endfunction

  task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s[lat%0d]: observed %h expected %h", tag, lat_of(k), obs, exp);
    end
  endtask

  task automatic chk_quiet(string tag, int k);
    chk({tag, ".stallM"}, k, 32'(st[k]), 32'(0));
    chk({tag, ".rdata_valid"}, k, 32'(dv[k]), 32'(0));
    chk({tag, ".err"}, k, 32'(er[k]), 32'(0));
    if (hold_ok[k]) chk({tag, ".rdataM_hold"}, k, rd[k], hold[k]);
  endtask

  task automatic idle(int k);
    rv[k] = 1'b0;
    #2;
    chk_quiet("idle", k);
    @(posedge clk); #1;
  endtask

  task automatic xact(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input int abort_at, output logic [31:0] rdo);
    int lat = lat_of(k);
    int i = widx(a);
    bit m = mis(be, a[1:0]);
    rdo = 'x;
    for (int c = 0; c <= lat; c++) begin
      if (c == 0) begin
        rv[k] = 1'b1; rw[k] = wr; ra[k] = a; rwd[k] = d; rbe[k] = be;
      end else begin
        rw[k] = 1'($urandom); ra[k] = $urandom; rwd[k] = $urandom; rbe[k] = 4'($urandom);
      end
      if (c > 0 && c == abort_at) begin
        rv[k] = 1'b0;
        #2;
        chk_quiet("abort", k);
        @(posedge clk); #1;
        #2;
        chk_quiet("after_abort", k);
        @(posedge clk); #1;
        return;
      end
      #2;
      chk("stallM", k, 32'(st[k]), 32'(c < lat));
      chk("rdata_valid", k, 32'(dv[k]), 32'(c == lat));
      chk("err", k, 32'(er[k]), 32'(c == lat && m));
      if (c == lat) begin
        rdo = rd[k];
        if (known[k][i]) chk("rdataM", k, rd[k], mem[k][i]);
        hold[k] = mem[k][i];
        hold_ok[k] = known[k][i];
        if (wr && !m) begin
          for (int b = 0; b < 4; b++) if (be[b]) mem[k][i][8*b +: 8] = d[8*b +: 8];
          if (be == 4'hF) known[k][i] = 1'b1;
        end
      end else if (hold_ok[k]) chk("rdataM_hold", k, rd[k], hold[k]);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rv[k] = 0; rw[k] = 0; ra[k] = 0; rwd[k] = 0; rbe[k] = 0;
      hold[k] = 0; hold_ok[k] = 1;
    end
    #3;
    for (int k = 0; k < 3; k++) begin
      chk("reset.stallM", k, 32'(st[k]), 0);
      chk("reset.rdata_valid", k, 32'(dv[k]), 0);
      chk("reset.err", k, 32'(er[k]), 0);
      chk("reset.rdataM", k, rd[k], 0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    xact(1, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, got);
    idle(1);
    xact(1, 0, 32'h10, 32'h0, 4'hF, 0, got);
    chk("t2.load", 1, got, 32'hDEADBEEF);
    idle(1);
    xact(1, 1, 32'h12, 32'h00AA0000, 4'b0100, 0, got);
    xact(1, 0, 32'h10, 32'h0, 4'hF, 0, got);
    chk("t3.byte_merge", 1, got, 32'hDEAABEEF);
    idle(1);
    xact(1, 1, 32'h11, 32'h01234567, 4'hF, 0, got);
    xact(1, 0, 32'h10, 32'h0, 4'hF, 0, got);
    chk("t4.err_no_write", 1, got, 32'hDEAABEEF);
    idle(1);
    xact(1, 1, 32'h20, 32'h55667788, 4'hF, 0, got);
    idle(1);
    xact(1, 1, 32'h20, 32'hFFFFFFFF, 4'hF, 1, got);
    xact(1, 0, 32'h20, 32'h0, 4'hF, 0, got);
    chk("t5.flush_no_write", 1, got, 32'h55667788);
    idle(1);
    xact(2, 1, 32'h40, 32'hCAFEF00D, 4'hF, 0, got);
    rv[2] = 1; rw[2] = 1; ra[2] = 32'h40; rwd[2] = 32'h11111111; rbe[2] = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("t6.rst.stallM", 2, 32'(st[2]), 0);
    chk("t6.rst.rdata_valid", 2, 32'(dv[2]), 0);
    chk("t6.rst.err", 2, 32'(er[2]), 0);
    chk("t6.rst.rdataM", 2, rd[2], 0);
    @(posedge clk); #1;
    rv[2] = 0;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin hold[k] = 0; hold_ok[k] = 1; end
    xact(2, 0, 32'h40, 32'h0, 4'hF, 0, got);
    chk("t6.rst_no_write", 2, got, 32'hCAFEF00D);
    idle(2);
    for (int w = 0; w < 16; w++)
      for (int k = 0; k < 3; k++) begin
        xact(k, 1, 32'(w * 4), $urandom, 4'hF, 0, got);
        idle(k);
      end
    for (int w = 0; w < 4; w++) xact(0, 0, 32'(w * 4), 32'h0, 4'hF, 0, got);
    idle(0);
    for (int n = 0; n < 300; n++) begin
      int k = $urandom_range(0, 2);
      int lat = lat_of(k);
      logic [3:0] be = ($urandom_range(0, 7) == 0) ? 4'($urandom) : bes[$urandom_range(0, 6)];
      logic [31:0] a = ($urandom << 12) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
      int ab = (lat > 1 && $urandom_range(0, 9) == 0) ? $urandom_range(1, lat - 1) : 0;
      for (int j = 0; j < 3; j++) if (j != k) rv[j] = 1'b0;
      xact(k, 1'($urandom), a, $urandom, be, ab, got);
      if ($urandom_range(0, 1) == 0) idle(k);
    end
    for (int k = 0; k < 3; k++) idle(k);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
